// File: rtl/matmul_host_ctrl.sv
// Host-side sequencer for the 16x16 int8 matmul accelerator: loads A/B operands,
// kicks the multiply, waits for completion and streams OMEM results out.
module matmul_host_ctrl #(
    parameter int TIMEOUT = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_fl,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [15:0] i_in_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_data,
    output logic        o_mm_cen,
    output logic        o_mm_wen,
    output logic [8:0]  o_mm_addr,
    output logic [31:0] o_mm_din,
    input  logic [31:0] i_mm_dout,
    output logic        o_mm_rstn,
    output logic        o_mm_en,
    output logic [2:0]  o_mm_fl,
    input  logic        i_mm_done
);

    localparam int TW = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_KICK = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_READ = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [8:0]    rcnt_q, rcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
    logic [2:0]    fl_q, fl_d;
    logic          inflight_q;
    logic          wptr_q, rptr_q;
    logic [1:0]    fcnt_q, fcnt_d;
    logic [31:0]   fifo_q [2];

    logic          in_hs;
    logic          push;
    logic          pop;
    logic [1:0]    occ;
    logic          issue;

    assign in_hs = (state_q == S_LOAD) && i_in_valid;
    assign push  = inflight_q;
    assign pop   = (fcnt_q != 2'd0) && i_out_ready;
    assign fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop};

    // Occupancy counts a word leaving this cycle as free, so reads sustain 1/cycle.
    assign occ   = fcnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue = (state_q == S_READ) && !rcnt_q[8] && (occ < 2'd2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;
        fl_d    = fl_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    fl_d    = i_fl;
                    err_d   = 1'b0;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                cnt_d   = 8'd0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (in_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd255) begin
                        state_d = S_KICK;
                    end
                end
            end
            S_KICK: begin
                tcnt_d  = '0;
                rcnt_d  = 9'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + 1'b1;
                if (i_mm_done) begin
                    state_d = S_READ;
                end else if (tcnt_q == TW'(TIMEOUT - 2)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_READ: begin
                if (issue) begin
                    rcnt_d = rcnt_q + 9'd1;
                end
                // Finished once every read is issued, none in flight, FIFO drained.
                if (rcnt_q[8] && !inflight_q && (fcnt_d == 2'd0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            rcnt_q     <= 9'd0;
            tcnt_q     <= '0;
            err_q      <= 1'b0;
            fl_q       <= 3'd0;
            inflight_q <= 1'b0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            fcnt_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rcnt_q     <= rcnt_d;
            tcnt_q     <= tcnt_d;
            err_q      <= err_d;
            fl_q       <= fl_d;
            inflight_q <= issue;
            fcnt_q     <= fcnt_d;
            if (push) begin
                wptr_q <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wptr_q] <= i_mm_dout;
        end
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_err       = err_q;
    assign o_in_ready  = (state_q == S_LOAD);
    assign o_out_valid = (fcnt_q != 2'd0);
    assign o_out_data  = fifo_q[rptr_q];
    assign o_mm_cen    = !(in_hs || issue);
    assign o_mm_wen    = !in_hs;
    assign o_mm_addr   = in_hs ? {1'b0, cnt_q} : (issue ? {1'b1, rcnt_q[7:0]} : 9'd0);
    assign o_mm_din    = in_hs ? {16'h0, i_in_data} : 32'd0;
    assign o_mm_rstn   = !(i_rst || (state_q == S_CLR));
    assign o_mm_en     = (state_q == S_KICK) || (state_q == S_WAIT);
    assign o_mm_fl     = fl_q;

endmodule
